// File: rtl/bcd_cnt_pkg.sv
// Shared constants and helpers for the multi-digit BCD counter.
// Optional feature macro: BCD_COUNTER_SAT_EN (saturate instead of wrap).
package bcd_cnt_pkg;

    localparam int         DIGIT_W       = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam int         MAX_DIGITS    = 8;

    function automatic logic digit_legal(input logic [DIGIT_W-1:0] digit);
        return digit <= BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the counter datapath: steps the nibble up or down by one
// when carry/borrow comes in, and reports a carry/borrow out.
module bcd_digit_step
    import bcd_cnt_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic               i_cin,
    input  logic               i_up,
    output logic [DIGIT_W-1:0] o_digit,
    output logic               o_cout
);

    always_comb begin
        o_digit = i_digit;
        o_cout  = 1'b0;
        if (i_cin) begin
            if (i_up) begin
                if (i_digit >= BCD_MAX_DIGIT) begin
                    o_digit = '0;
                    o_cout  = 1'b1;
                end else begin
                    o_digit = i_digit + DIGIT_W'(1);
                end
            end else begin
                if (i_digit == '0) begin
                    o_digit = BCD_MAX_DIGIT;
                    o_cout  = 1'b1;
                end else begin
                    o_digit = i_digit - DIGIT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter_nd.sv
// Up/down packed-BCD counter with parallel load, programmable limit MAX,
// terminal-count and sticky illegal-load flags. Macro BCD_COUNTER_SAT_EN selects saturation.
module bcd_counter_nd
    import bcd_cnt_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int W      = 4 * DIGITS
) (
    input  logic         CP,
    input  logic         CR,
    input  logic         CE,
    input  logic         UP,
    input  logic         PE,
    input  logic [W-1:0] D,
    input  logic [W-1:0] MAX,
    output logic [W-1:0] Q,
    output logic         TC,
    output logic         ERR
);

    generate
        if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
            $error("bcd_counter_nd: DIGITS must be in 1..8");
        end
    endgenerate

    logic [W-1:0]      r_q;
    logic              r_tc;
    logic              r_err;

    logic [DIGITS:0]   w_carry;
    logic [W-1:0]      w_step;
    logic [DIGITS-1:0] w_nib_ok;
    logic              w_load_ok;
    logic              w_q_zero;
    logic [W-1:0]      w_q_next;
    logic              w_tc_next;
    logic              w_err_next;

    // Ripple chain: a forced carry/borrow into digit 0 gives Q+1 or Q-1 in BCD.
    assign w_carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_step u_step (
                .i_digit (r_q[gi*DIGIT_W +: DIGIT_W]),
                .i_cin   (w_carry[gi]),
                .i_up    (UP),
                .o_digit (w_step[gi*DIGIT_W +: DIGIT_W]),
                .o_cout  (w_carry[gi+1])
            );
            assign w_nib_ok[gi] = digit_legal(D[gi*DIGIT_W +: DIGIT_W]);
        end
    endgenerate

    // A borrow out of the top digit on a down step happens only when every digit is 0.
    assign w_q_zero  = ~UP & w_carry[DIGITS];
    // With valid BCD nibbles a plain unsigned compare is the digit-wise compare.
    assign w_load_ok = (&w_nib_ok) && (D <= MAX);

    always_comb begin
        w_q_next   = r_q;
        w_err_next = r_err;
        if (PE) begin
            if (w_load_ok) begin
                w_q_next = D;
            end else begin
                w_q_next   = '0;
                w_err_next = 1'b1;
            end
        end else if (UP) begin
            if (r_q < MAX) begin
                w_q_next = w_step;
            end else begin
`ifdef BCD_COUNTER_SAT_EN
                w_q_next = MAX;
`else
                w_q_next = '0;
`endif
            end
        end else begin
`ifdef BCD_COUNTER_SAT_EN
            if (r_q > MAX) begin
                w_q_next = MAX;
            end else if (w_q_zero) begin
                w_q_next = '0;
            end else begin
                w_q_next = w_step;
            end
`else
            if (w_q_zero || (r_q > MAX)) begin
                w_q_next = MAX;
            end else begin
                w_q_next = w_step;
            end
`endif
        end
        w_tc_next = UP ? (w_q_next == MAX) : (w_q_next == '0);
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            r_q   <= '0;
            r_tc  <= 1'b0;
            r_err <= 1'b0;
        end else if (CE) begin
            r_q   <= w_q_next;
            r_tc  <= w_tc_next;
            r_err <= w_err_next;
        end
    end

    assign Q   = r_q;
    assign TC  = r_tc;
    assign ERR = r_err;

endmodule

// File: tb/tb_bcd_counter_nd.sv
// Self-checking bench for bcd_counter_nd (DIGITS=4): directed scenarios plus
// randomized operations against a decimal-arithmetic reference model.
module tb_bcd_counter_nd;

    logic        CP;
    logic        CR;
    logic        CE;
    logic        UP;
    logic        PE;
    logic [15:0] D;
    logic [15:0] MAX;
    logic [15:0] Q;
    logic        TC;
    logic        ERR;

    int errors = 0;
    int checks = 0;

    // Reference model state, kept as plain decimal numbers.
    int   m_q   = 0;
    logic m_tc  = 1'b0;
    logic m_err = 1'b0;

    bcd_counter_nd #(.DIGITS(4)) dut (
        .CP  (CP),
        .CR  (CR),
        .CE  (CE),
        .UP  (UP),
        .PE  (PE),
        .D   (D),
        .MAX (MAX),
        .Q   (Q),
        .TC  (TC),
        .ERR (ERR)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic bit digits_ok(input logic [15:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r = '0;
        int t = n;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Next model state from the current inputs, following the counting rules directly.
    task automatic model_edge();
        int mx;
        int nq;
        if (!CE) return;
        mx = bcd2int(MAX);
        nq = m_q;
        if (PE) begin
            if (digits_ok(D) && bcd2int(D) <= mx) nq = bcd2int(D);
            else begin
                nq = 0;
                m_err = 1'b1;
            end
        end else if (UP) begin
`ifdef BCD_COUNTER_SAT_EN
            nq = (m_q < mx) ? m_q + 1 : mx;
`else
            nq = (m_q < mx) ? m_q + 1 : 0;
`endif
        end else begin
`ifdef BCD_COUNTER_SAT_EN
            if (m_q > mx) nq = mx;
            else if (m_q == 0) nq = 0;
            else nq = m_q - 1;
`else
            nq = (m_q > 0 && m_q <= mx) ? m_q - 1 : mx;
`endif
        end
        m_tc = UP ? (nq == mx) : (nq == 0);
        m_q  = nq;
    endtask

    task automatic tick();
        model_edge();
        @(posedge CP);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CP);
        CR = 1'b1;
        m_q = 0; m_tc = 1'b0; m_err = 1'b0;
        @(negedge CP);
        CR = 1'b0;
    endtask

    task automatic test_reset();
        CR = 1'b1; CE = 1'b0; UP = 1'b1; PE = 1'b0; D = '0; MAX = 16'h0059;
        #3;
        checks++;
        if (Q !== 16'h0000 || TC !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got Q=%h TC=%b ERR=%b, required Q=0000 TC=0 ERR=0", Q, TC, ERR);
        end
        @(negedge CP);
        CR = 1'b0;
        m_q = 0; m_tc = 1'b0; m_err = 1'b0;
        $display("reset: Q=%h TC=%b ERR=%b", Q, TC, ERR);
    endtask

    task automatic test_up_wrap();
        CE = 1'b1; UP = 1'b1; PE = 1'b0; MAX = 16'h0059;
        for (int k = 1; k <= 60; k++) begin
            logic [15:0] exp_q;
            logic        exp_tc;
            exp_q  = int2bcd(k % 60);
            exp_tc = (k == 59);
            tick();
            checks++;
            if (Q !== exp_q || TC !== exp_tc) begin
                errors++;
                $display("FAIL up_wrap edge %0d: got Q=%h TC=%b, required Q=%h TC=%b", k, Q, TC, exp_q, exp_tc);
            end
            $display("up_wrap edge %0d: Q=%h TC=%b", k, Q, TC);
        end
    endtask

    task automatic test_hold();
        logic [15:0] held_q;
        logic        held_tc;
        logic        held_err;
        held_q = Q; held_tc = TC; held_err = ERR;
        CE = 1'b0;
        for (int k = 0; k < 5; k++) begin
            UP = 1'($urandom); PE = 1'($urandom); D = 16'($urandom);
            tick();
            checks++;
            if (Q !== held_q || TC !== held_tc || ERR !== held_err) begin
                errors++;
                $display("FAIL hold %0d: got Q=%h TC=%b ERR=%b, required Q=%h TC=%b ERR=%b",
                         k, Q, TC, ERR, held_q, held_tc, held_err);
            end
            $display("hold %0d: Q=%h", k, Q);
        end
        CE = 1'b1; PE = 1'b0;
    endtask

    task automatic test_load_down();
        CE = 1'b1; MAX = 16'h0999; PE = 1'b1; D = 16'h0100; UP = 1'b1;
        tick();
        checks++;
        if (Q !== 16'h0100) begin
            errors++;
            $display("FAIL load: got Q=%h, required Q=0100", Q);
        end
        PE = 1'b0; UP = 1'b0;
        tick();
        checks++;
        if (Q !== 16'h0099) begin
            errors++;
            $display("FAIL down_borrow: got Q=%h, required Q=0099", Q);
        end
        tick();
        checks++;
        if (Q !== 16'h0098) begin
            errors++;
            $display("FAIL down_step: got Q=%h, required Q=0098", Q);
        end
        $display("load_down: Q=%h", Q);
    endtask

    task automatic test_illegal_load();
        CE = 1'b1; PE = 1'b1; UP = 1'b1; D = 16'h00A3;
        tick();
        checks++;
        if (Q !== 16'h0000 || ERR !== 1'b1) begin
            errors++;
            $display("FAIL illegal_load: got Q=%h ERR=%b, required Q=0000 ERR=1", Q, ERR);
        end
        PE = 1'b0;
        for (int k = 0; k < 20; k++) begin
            UP = 1'($urandom);
            tick();
            checks++;
            if (ERR !== 1'b1) begin
                errors++;
                $display("FAIL err_sticky count %0d: got ERR=%b, required ERR=1", k, ERR);
            end
        end
        do_reset();
        checks++;
        if (ERR !== 1'b0 || Q !== 16'h0000) begin
            errors++;
            $display("FAIL err_clear: got ERR=%b Q=%h, required ERR=0 Q=0000", ERR, Q);
        end
        $display("illegal_load: ERR=%b after reset", ERR);
    endtask

    task automatic test_down_from_zero();
        do_reset();
        CE = 1'b1; PE = 1'b0; UP = 1'b0; MAX = 16'h0059;
        tick();
        checks++;
`ifdef BCD_COUNTER_SAT_EN
        if (Q !== 16'h0000 || TC !== 1'b1) begin
            errors++;
            $display("FAIL down_from_zero: got Q=%h TC=%b, required Q=0000 TC=1", Q, TC);
        end
`else
        if (Q !== 16'h0059 || TC !== 1'b0) begin
            errors++;
            $display("FAIL down_from_zero: got Q=%h TC=%b, required Q=0059 TC=0", Q, TC);
        end
`endif
        $display("down_from_zero: Q=%h TC=%b", Q, TC);
    endtask

    task automatic test_max_lowered();
        CE = 1'b1; PE = 1'b1; UP = 1'b1; MAX = 16'h0059; D = 16'h0045;
        tick();
        checks++;
        if (Q !== 16'h0045) begin
            errors++;
            $display("FAIL max_lowered_load: got Q=%h, required Q=0045", Q);
        end
        PE = 1'b0; MAX = 16'h0030;
        tick();
        checks++;
`ifdef BCD_COUNTER_SAT_EN
        if (Q !== 16'h0030 || TC !== 1'b1) begin
            errors++;
            $display("FAIL max_lowered: got Q=%h TC=%b, required Q=0030 TC=1", Q, TC);
        end
`else
        if (Q !== 16'h0000 || TC !== 1'b0) begin
            errors++;
            $display("FAIL max_lowered: got Q=%h TC=%b, required Q=0000 TC=0", Q, TC);
        end
`endif
        $display("max_lowered: Q=%h TC=%b", Q, TC);
    endtask

    task automatic test_async_reset();
        CE = 1'b1; UP = 1'b1; MAX = 16'h0059; PE = 1'b1; D = 16'h0011;
        tick();
        D = 16'h0042;
        @(negedge CP);
        CR = 1'b1;
        m_q = 0; m_tc = 1'b0; m_err = 1'b0;
        #1;
        checks++;
        if (Q !== 16'h0000 || TC !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: got Q=%h TC=%b ERR=%b, required Q=0000 TC=0 ERR=0", Q, TC, ERR);
        end
        @(posedge CP);
        #1;
        checks++;
        if (Q !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset_no_load: got Q=%h, required Q=0000", Q);
        end
        @(negedge CP);
        CR = 1'b0;
        tick();
        checks++;
        if (Q !== 16'h0042) begin
            errors++;
            $display("FAIL reset_resume_load: got Q=%h, required Q=0042", Q);
        end
        PE = 1'b0;
        $display("async_reset: Q=%h", Q);
    endtask

    task automatic test_random();
        MAX = int2bcd(int'($urandom_range(0, 9999)));
        for (int k = 0; k < 300; k++) begin
            logic [15:0] exp_q;
            bit          nib_bad;
            CE = ($urandom_range(0, 9) != 0);
            UP = 1'($urandom);
            PE = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) == 0) D = 16'($urandom);
            else D = int2bcd(int'($urandom_range(0, 9999)));
            if ($urandom_range(0, 19) == 0) MAX = int2bcd(int'($urandom_range(0, 9999)));
            tick();
            exp_q = int2bcd(m_q);
            nib_bad = (m_err == 1'b0) && !digits_ok(Q);
            checks++;
            if (Q !== exp_q || TC !== m_tc || ERR !== m_err || nib_bad) begin
                errors++;
                $display("FAIL random %0d: got Q=%h TC=%b ERR=%b, required Q=%h TC=%b ERR=%b",
                         k, Q, TC, ERR, exp_q, m_tc, m_err);
            end
            $display("random %0d: CE=%b PE=%b UP=%b D=%h MAX=%h -> Q=%h TC=%b ERR=%b",
                     k, CE, PE, UP, D, MAX, Q, TC, ERR);
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_hold();
        test_load_down();
        test_illegal_load();
        test_down_from_zero();
        test_max_lowered();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
